mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the instruction-fetch stage (read-only) and the load/store unit (read/write).
- Fixed priority to data accesses, with a starvation guard so fetch is never locked out.
- One outstanding transaction at a time, with a bus timeout that returns an error instead of hanging the pipeline.
- Sits between the pipeline front/back ends and the top-level memory bus.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_MAX, 4, consecutive data wins allowed while fetch waits before fetch is forced
- TIMEOUT, 255, maximum BUSY cycles waiting for mem_ready before abort; 8-bit counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: if_rdata/if_err valid
- if_rdata  out  DATA_W  fetched word
- if_err  out  1  timeout on fetch, qualified by if_valid
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wstrb  in  DATA_W/8  byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_valid  out  1  one-cycle pulse: completion (read data or write ack)
- d_rdata  out  DATA_W  read data; 0 for writes
- d_err  out  1  timeout on data, qualified by d_valid
- mem_req  out  1  bus request; held until mem_ready or timeout
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_wstrb  out  DATA_W/8  bus byte enables
- mem_rdata  in  DATA_W  bus read data, valid with mem_ready
- mem_ready  in  1  bus completion

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0: gnt, valid, err, rdata, and all mem_* signals.
  - starve_cnt=0, to_cnt=0.
  - mem_req drops immediately; an in-flight transaction is abandoned with no valid pulse.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- IDLE arbitration (evaluated every cycle):
  - Data wins if d_req, unless if_req && starve_cnt==STARVE_MAX, in which case fetch wins.
  - Otherwise fetch wins if if_req.
- On a win at edge N:
  - The matching gnt pulses high in cycle N+1.
  - Winner's address and payload are registered onto mem_*; mem_req=1 from N+1.
  - Fetch wins drive mem_we=0, mem_wstrb=all-ones, mem_wdata=0.
- Starvation counter:
  - Increments (saturating) when data wins while if_req=1.
  - Clears when fetch wins.
  - Unchanged otherwise.
- BUSY_x:
  - mem_* held stable; no new grants.
  - to_cnt increments each cycle.
- BUSY completion, first cycle with mem_ready=1:
  - Next cycle: x_valid=1 for exactly one cycle.
  - x_rdata = mem_rdata for reads, 0 for writes; x_err=0.
  - mem_req=0; state=IDLE; to_cnt=0.
- Timeout, to_cnt==TIMEOUT with no mem_ready:
  - Next cycle: x_valid=1, x_err=1, x_rdata=0, mem_req=0; state=IDLE.
  - mem_ready arriving in the same cycle as the timeout counts as success.
- Latency:
  - Idle bus, mem_ready the cycle after mem_req rises: req@0, gnt@1, mem_req@1–2, valid@3.
  - Minimum 1 IDLE cycle between transactions.
- Boundary rules:
  - x_rdata holds its last value between valid pulses.
  - gnt and valid are never asserted for both ports in the same cycle.
  - Requests dropped before gnt are ignored.
  - mem_ready in IDLE is ignored.

Decomposition:
- Shared package cpu_mem_pkg: state enum {IDLE, BUSY_IF, BUSY_D}, port-ID constants, NOP/zero data constants.
- One natural sub-module: mem_arb_timeout, a loadable 8-bit counter with a clear input and an expired flag.

Test Plan:
- Fetch only: if_req, if_addr=0x10, mem_ready one cycle after mem_req with mem_rdata=0x00100093 -> if_gnt@1, mem_addr=0x10, mem_we=0, if_valid@3, if_rdata=0x00100093, if_err=0.
- Simultaneous: if_req and d_req (write, addr 0x200, wdata 0xDEADBEEF, wstrb 0xF) at cycle 0 -> d_gnt first, mem_we=1; d_valid with d_rdata=0; fetch served next, if_gnt after the IDLE cycle.
- Starvation: d_req held continuously with if_req asserted -> exactly 4 data grants, then if_gnt; starve_cnt returns to 0.
- Timeout: d_req read, mem_ready held 0 -> mem_req high 255 cycles, then d_valid=1, d_err=1, d_rdata=0; next request accepted normally.
- Reset mid-operation: reset_n=0 during BUSY_D -> mem_req=0 immediately, no d_valid; after release, IDLE with all outputs 0 and if_req served normally.
- Byte write: d_wstrb=0x3, d_addr=0x204 -> mem_wstrb=0x3, mem_addr=0x204 stable until mem_ready; stale mem_ready in IDLE produces no valid pulse.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding,
// requester IDs, timeout counter constants and the arbitration rule.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_e;

  // Requester selected by one arbitration decision
  localparam logic [1:0] PORT_NONE = 2'd0;
  localparam logic [1:0] PORT_IF   = 2'd1;
  localparam logic [1:0] PORT_D    = 2'd2;

  // Timeout counter is 8 bits; a new transaction loads 1 so the count
  // equals the number of BUSY cycles elapsed, including the current one.
  localparam int         TO_W     = 8;
  localparam logic [7:0] TO_START = 8'd1;

  // Data has priority unless fetch is waiting and has been starved out.
  function automatic logic [1:0] arb_pick(input logic if_req,
                                          input logic d_req,
                                          input logic starve_full);
    if (d_req && !(if_req && starve_full)) return PORT_D;
    else if (if_req)                       return PORT_IF;
    else                                   return PORT_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Loadable 8-bit bus-timeout counter with synchronous clear and an
// expired flag that is high while the count equals LIMIT.
module mem_arb_timeout
  import cpu_mem_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic [TO_W-1:0] i_load_val,
  input  logic            i_en,
  output logic            o_expired
);

  localparam logic [TO_W-1:0] LP_LIMIT = TO_W'(LIMIT);
  localparam logic [TO_W-1:0] LP_SAT   = '1;

  logic [TO_W-1:0] r_cnt;

  // Clear has priority over load, load over counting; count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != LP_SAT)) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign o_expired = (r_cnt == LP_LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (read-only)
// and the load/store unit. Data has fixed priority, a starvation counter
// forces fetch through after STARVE_MAX consecutive data wins, and a bus
// timeout completes a hung transaction with an error.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  // fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  // memory bus
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int              SC_W   = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  arb_state_e      r_state;
  logic [SC_W-1:0] r_starve_cnt;

  logic       w_starve_full;
  logic [1:0] w_pick;
  logic       w_busy;
  logic       w_to_expired;
  logic       w_to_load;
  logic       w_to_clear;
  logic       w_done;

  assign w_starve_full = (r_starve_cnt == SC_MAX);
  assign w_pick        = arb_pick(if_req, d_req, w_starve_full);
  assign w_busy        = (r_state != IDLE);
  // mem_ready on the expiry cycle still completes as a success
  assign w_done        = w_busy && (mem_ready || w_to_expired);
  assign w_to_load     = (r_state == IDLE) && (w_pick != PORT_NONE);
  assign w_to_clear    = w_done;

  mem_arb_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_clear    (w_to_clear),
    .i_load     (w_to_load),
    .i_load_val (TO_START),
    .i_en       (w_busy),
    .o_expired  (w_to_expired)
  );

  // Arbitration FSM: grants, bus drive, completion pulses and starvation count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      if_gnt       <= 1'b0;
      if_valid     <= 1'b0;
      if_rdata     <= '0;
      if_err       <= 1'b0;
      d_gnt        <= 1'b0;
      d_valid      <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
    end else begin
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_err   <= 1'b0;
      d_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick == PORT_D) begin
            r_state   <= BUSY_D;
            d_gnt     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
            if (if_req && !w_starve_full) begin
              r_starve_cnt <= r_starve_cnt + SC_W'(1);
            end
          end else if (w_pick == PORT_IF) begin
            r_state      <= BUSY_IF;
            if_gnt       <= 1'b1;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= if_addr;
            mem_wdata    <= '0;
            mem_wstrb    <= '1;
            r_starve_cnt <= '0;
          end
        end
        BUSY_IF: begin
          if (w_done) begin
            r_state  <= IDLE;
            mem_req  <= 1'b0;
            if_valid <= 1'b1;
            if_err   <= !mem_ready;
            if_rdata <= mem_ready ? mem_rdata : '0;
          end
        end
        BUSY_D: begin
          if (w_done) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
            d_valid <= 1'b1;
            d_err   <= !mem_ready;
            d_rdata <= (mem_ready && !mem_we) ? mem_rdata : '0;
          end
        end
        default: begin
          r_state <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int SMAX = 4;
  localparam int TMO  = 255;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          if_req, if_gnt, if_valid, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_valid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [SW-1:0] d_wstrb;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h88; d_wdata = '1; d_wstrb = '1;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) tick();
    n_vec++; if ({if_gnt, d_gnt, if_valid, d_valid} !== 4'b0) begin n_err++; $display("FAIL rst_pulses got=%b want=0000", {if_gnt, d_gnt, if_valid, d_valid}); end
    n_vec++; if ({if_err, d_err, mem_req, mem_we} !== 4'b0) begin n_err++; $display("FAIL rst_flags got=%b want=0000", {if_err, d_err, mem_req, mem_we}); end
    n_vec++; if (if_rdata !== '0 || d_rdata !== '0) begin n_err++; $display("FAIL rst_rdata got=%h/%h want=0/0", if_rdata, d_rdata); end
    n_vec++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== '0) begin n_err++; $display("FAIL rst_mem got=%h/%h/%h want=0", mem_addr, mem_wdata, mem_wstrb); end
    idle_inputs();
    reset_n = 1'b1;
    tick();
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_release_memreq got=%b want=0", mem_req); end
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    n_vec++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_err++; $display("FAIL fetch_gnt got=%b%b want=10", if_gnt, d_gnt); end
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_bus got req=%b addr=%h we=%b want 1/10/0", mem_req, mem_addr, mem_we); end
    n_vec++; if (mem_wstrb !== 4'hF || mem_wdata !== '0) begin n_err++; $display("FAIL fetch_strb got=%h wdata=%h want F/0", mem_wstrb, mem_wdata); end
    if_req = 1'b0;
    tick();
    n_vec++; if (if_gnt !== 1'b0 || mem_req !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL fetch_c2 got gnt=%b req=%b valid=%b want 0/1/0", if_gnt, mem_req, if_valid); end
    mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
    tick();
    mem_ready = 1'b0; mem_rdata = 32'hAAAA_5555;
    n_vec++; if (if_valid !== 1'b1 || if_rdata !== 32'h0010_0093 || if_err !== 1'b0) begin n_err++; $display("FAIL fetch_valid got v=%b d=%h e=%b want 1/00100093/0", if_valid, if_rdata, if_err); end
    n_vec++; if (mem_req !== 1'b0 || d_valid !== 1'b0) begin n_err++; $display("FAIL fetch_c3 got req=%b dvalid=%b want 0/0", mem_req, d_valid); end
    tick();
    n_vec++; if (if_valid !== 1'b0 || if_rdata !== 32'h0010_0093) begin n_err++; $display("FAIL fetch_hold got v=%b d=%h want 0/00100093", if_valid, if_rdata); end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    tick();
    n_vec++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_err++; $display("FAIL simul_gnt got d=%b if=%b want 1/0", d_gnt, if_gnt); end
    n_vec++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF) begin n_err++; $display("FAIL simul_bus got we=%b a=%h w=%h s=%h", mem_we, mem_addr, mem_wdata, mem_wstrb); end
    d_req = 1'b0;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 1'b0;
    n_vec++; if (d_valid !== 1'b1 || d_rdata !== '0 || d_err !== 1'b0) begin n_err++; $display("FAIL simul_dvalid got v=%b d=%h e=%b want 1/0/0", d_valid, d_rdata, d_err); end
    n_vec++; if (if_gnt !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL simul_idle got ifgnt=%b ifvalid=%b want 0/0", if_gnt, if_valid); end
    tick();
    n_vec++; if (if_gnt !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin n_err++; $display("FAIL simul_fetch got gnt=%b a=%h we=%b want 1/40/0", if_gnt, mem_addr, mem_we); end
    if_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ready = 1'b0;
    n_vec++; if (if_valid !== 1'b1 || if_rdata !== 32'hCAFE_0001 || d_rdata !== '0) begin n_err++; $display("FAIL simul_fvalid got v=%b d=%h dd=%h", if_valid, if_rdata, d_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    int seq[$];
    int want[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int cyc;
    cyc = 0;
    if_req = 1'b1; if_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000; d_wdata = '0; d_wstrb = '1;
    while (seq.size() < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (d_gnt) begin seq.push_back(1); d_addr = d_addr + 32'd4; end
      if (if_gnt) begin seq.push_back(0); if_addr = if_addr + 32'd4; end
      mem_ready = mem_req && !if_gnt && !d_gnt;
      mem_rdata = $urandom();
    end
    d_req = 1'b0; if_req = 1'b0;
    n_vec++; if (seq.size() != 10) begin n_err++; $display("FAIL starve_grants got=%0d want=10", seq.size()); end
    for (int i = 0; i < seq.size() && i < 10; i++) begin
      n_vec++; if (seq[i] != want[i]) begin n_err++; $display("FAIL starve_order[%0d] got=%0d want=%0d (1=data)", i, seq[i], want[i]); end
    end
    repeat (4) begin tick(); mem_ready = mem_req; end
    mem_ready = 1'b0;
  endtask

  task automatic test_byte_write();
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    tick();
    n_vec++; if (if_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL stale_ready got iv=%b dv=%b req=%b want 0", if_valid, d_valid, mem_req); end
    mem_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'h0000_BEEF; d_wstrb = 4'h3;
    tick();
    d_req = 1'b0;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL bw_gnt got=%b want=1", d_gnt); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (mem_req !== 1'b1 || mem_wstrb !== 4'h3 || mem_addr !== 32'h204 || d_valid !== 1'b0) begin n_err++; $display("FAIL bw_stable[%0d] got req=%b s=%h a=%h v=%b", i, mem_req, mem_wstrb, mem_addr, d_valid); end
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    n_vec++; if (d_valid !== 1'b1 || d_rdata !== '0 || d_err !== 1'b0) begin n_err++; $display("FAIL bw_valid got v=%b d=%h e=%b want 1/0/0", d_valid, d_rdata, d_err); end
    tick();
    mem_ready = 1'b0;
    n_vec++; if (d_valid !== 1'b0 || if_valid !== 1'b0) begin n_err++; $display("FAIL bw_stale got dv=%b iv=%b want 0/0", d_valid, if_valid); end
  endtask

  task automatic test_timeout();
    int  cnt;
    logic got;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    mem_ready = 1'b0; mem_rdata = '1;
    tick();
    d_req = 1'b0;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL to_gnt got=%b want=1", d_gnt); end
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (d_valid) got = 1'b1;
      else begin if (mem_req) cnt++; tick(); end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL to_novalid got=none want=d_valid"); end
    n_vec++; if (cnt != TMO) begin n_err++; $display("FAIL to_cycles got=%0d want=%0d", cnt, TMO); end
    n_vec++; if (d_err !== 1'b1 || d_rdata !== '0 || mem_req !== 1'b0) begin n_err++; $display("FAIL to_err got e=%b d=%h req=%b want 1/0/0", d_err, d_rdata, mem_req); end
    tick();
    n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL to_pulse got=%b want=0", d_valid); end
    // mem_ready on the final allowed cycle completes normally
    d_req = 1'b1; d_addr = 32'h304; mem_rdata = 32'h5A5A_0304;
    tick();
    d_req = 1'b0;
    n_vec++; if (d_gnt !== 1'b1) begin n_err++; $display("FAIL to2_gnt got=%b want=1", d_gnt); end
    cnt = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (d_valid) got = 1'b1;
      else begin
        if (mem_req) cnt++;
        mem_ready = mem_req && (cnt == TMO);
        tick();
      end
    end
    mem_ready = 1'b0;
    n_vec++; if (!got || cnt != TMO) begin n_err++; $display("FAIL to2_cycles got=%0d valid=%b want=%0d/1", cnt, got, TMO); end
    n_vec++; if (d_err !== 1'b0 || d_rdata !== 32'h5A5A_0304) begin n_err++; $display("FAIL to2_data got e=%b d=%h want 0/5a5a0304", d_err, d_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    tick();
    d_req = 1'b0;
    tick();
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_busy got=%b want=1", mem_req); end
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    reset_n = 1'b0;
    #1;
    n_vec++; if (mem_req !== 1'b0 || d_valid !== 1'b0) begin n_err++; $display("FAIL rm_async got req=%b v=%b want 0/0", mem_req, d_valid); end
    tick();
    n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL rm_novalid got=%b want=0", d_valid); end
    mem_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    n_vec++; if ({if_gnt, d_gnt, if_valid, d_valid, if_err, d_err, mem_req, mem_we} !== 8'b0) begin n_err++; $display("FAIL rm_idle got=%b want=0", {if_gnt, d_gnt, if_valid, d_valid, if_err, d_err, mem_req, mem_we}); end
    n_vec++; if (d_rdata !== '0 || if_rdata !== '0 || mem_addr !== '0) begin n_err++; $display("FAIL rm_zero got %h/%h/%h want 0", d_rdata, if_rdata, mem_addr); end
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    if_req = 1'b0;
    n_vec++; if (if_gnt !== 1'b1 || mem_addr !== 32'h500) begin n_err++; $display("FAIL rm_fetch got gnt=%b a=%h want 1/500", if_gnt, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ready = 1'b0;
    n_vec++; if (if_valid !== 1'b1 || if_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rm_fvalid got v=%b d=%h want 1/0badf00d", if_valid, if_rdata); end
    tick();
  endtask

  task automatic test_random();
    logic          p_if, p_d, idle_prev, busy, own_d, exp_we, done_next;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, done_data, hold_if, hold_d, rd;
    logic [SW-1:0] exp_wstrb;
    int            starve, wait_cnt, win;
    p_if = 1'b0; p_d = 1'b0; idle_prev = 1'b1; busy = 1'b0; own_d = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
    done_next = 1'b0; done_data = '0; hold_if = 32'h0BAD_F00D; hold_d = '0;
    starve = 0; wait_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      win = 0;
      if (idle_prev) begin
        if (p_d && !(p_if && starve == SMAX)) win = 2;
        else if (p_if) win = 1;
      end
      n_vec++; if (if_gnt !== (win == 1) || d_gnt !== (win == 2)) begin n_err++; $display("FAIL rnd_gnt c=%0d got if=%b d=%b want winner=%0d", c, if_gnt, d_gnt, win); end
      if (win == 2) begin
        if (p_if && starve < SMAX) starve++;
        busy = 1'b1; own_d = 1'b1;
        exp_we = d_we; exp_addr = d_addr; exp_wdata = d_wdata; exp_wstrb = d_wstrb;
        d_req = 1'b0;
      end else if (win == 1) begin
        starve = 0;
        busy = 1'b1; own_d = 1'b0;
        exp_we = 1'b0; exp_addr = if_addr; exp_wdata = '0; exp_wstrb = '1;
        if_req = 1'b0;
      end
      n_vec++; if (if_valid !== (done_next && !own_d) || d_valid !== (done_next && own_d)) begin n_err++; $display("FAIL rnd_valid c=%0d got if=%b d=%b want done=%b owner_d=%b", c, if_valid, d_valid, done_next, own_d); end
      if (done_next) begin
        busy = 1'b0;
        if (own_d) hold_d = done_data; else hold_if = done_data;
        n_vec++; if (if_err !== 1'b0 || d_err !== 1'b0) begin n_err++; $display("FAIL rnd_err c=%0d got %b%b want 00", c, if_err, d_err); end
        done_next = 1'b0;
      end
      n_vec++; if (if_rdata !== hold_if || d_rdata !== hold_d) begin n_err++; $display("FAIL rnd_rdata c=%0d got %h/%h want %h/%h", c, if_rdata, d_rdata, hold_if, hold_d); end
      n_vec++; if (mem_req !== busy) begin n_err++; $display("FAIL rnd_memreq c=%0d got=%b want=%b", c, mem_req, busy); end
      if (busy) begin
        n_vec++; if (mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wdata || mem_wstrb !== exp_wstrb) begin n_err++; $display("FAIL rnd_bus c=%0d got %b/%h/%h/%h want %b/%h/%h/%h", c, mem_we, mem_addr, mem_wdata, mem_wstrb, exp_we, exp_addr, exp_wdata, exp_wstrb); end
      end
      // memory responder: random latency while busy, random stale ready while idle
      rd = $urandom();
      mem_rdata = rd;
      if (busy) begin
        if (win != 0) wait_cnt = $urandom_range(0, 3);
        if (wait_cnt == 0) begin
          mem_ready = 1'b1; done_next = 1'b1; done_data = exp_we ? '0 : rd;
        end else begin
          mem_ready = 1'b0; wait_cnt--;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      // requesters: occasionally withdraw, otherwise raise new requests
      if (if_req && $urandom_range(0, 15) == 0) if_req = 1'b0;
      if (d_req && $urandom_range(0, 15) == 0) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = $urandom(); end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom();
        d_wdata = $urandom(); d_wstrb = SW'($urandom());
      end
      p_if = if_req; p_d = d_req; idle_prev = !busy;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_byte_write();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
